dlsc_mt9v032_decoder: RTL and testbench
=======================================

# dlsc_mt9v032_decoder

Sits directly downstream of the MT9V032 LVDS deserializer and consumes its 10-bit word stream, which is qualified by `clk_en` and its framing status. It strips the embedded sync markers, tracks frame and line state, and emits active pixels with frame and line strobes. It measures line width and frame height, and flags protocol errors to the capture controller.

## Interface
Parameters:
- `XBITS`, 10: width of the pixel-per-line counter and of `out_width`.
- `YBITS`, 10: width of the line-per-frame counter and of `out_height`.
- `MAX_WIDTH`, 752: maximum pixels per line; the 753rd pixel is an overflow.
- `MAX_HEIGHT`, 480: maximum lines per frame; the 481st line start is an overflow.

Ports:
- `clk` in 1: px_clk*2, the same clock as the deserializer.
- `rst_n` in 1: reset, synchronous, active-low.
- `clk_en` in 1: px_clk beat; `in_data` is sampled only when this is high.
- `in_okay` in 1: deserializer framing okay (bitslip_okay).
- `in_data` in 10: deserialized word.
- `out_valid` out 1: pixel strobe.
- `out_data` out 10: pixel value, held between strobes.
- `out_frame_start`, `out_line_start`, `out_line_end`, `out_frame_end` out 1 each: single-cycle strobes.
- `out_width` out XBITS: pixel count of the last complete line.
- `out_height` out YBITS: line count of the last complete frame.
- `out_stats_valid` out 1: pulse when `out_width`/`out_height` update.
- `out_error` out 1: single-cycle protocol error pulse.

## Operation
- Marker format: `0x3FF`, `0x000`, code. Codes are `0x200` FS, `0x100` LS, `0x080` LE, `0x040` FE. Any other code is invalid.
- Window: two registers `w2` (older) and `w1`, each with a valid bit.
- On each `clk_en` beat with `in_okay` high:
  - If `w2`=`0x3FF` and `w1`=`0x000` (both valid): `in_data` is the code. Decode it, clear both valid bits, and do not load `in_data`.
  - Otherwise: if `w2` is valid, it is a data word and is processed. Then `w2`<=`w1` and `w1`<=`in_data`, with `w1` marked valid.
- State IDLE:
  - Data is discarded.
  - FS -> FRAME: pulse `out_frame_start`, set `line_cnt`=0.
  - Other codes are ignored, with no error.
- State FRAME (blanking):
  - Data is discarded silently.
  - LS -> LINE: set `pix_cnt`=0, pulse `out_line_start`. If `line_cnt`==`MAX_HEIGHT`: error and go to IDLE instead.
  - FE -> IDLE: pulse `out_frame_end` and `out_stats_valid`. Set `out_height`<=`line_cnt` and `out_width`<=`last_width`.
  - FS: error, then restart the frame (stay in FRAME, pulse `out_frame_start`, `line_cnt`=0).
  - LE: error, stay in FRAME.
  - Invalid code: error, go to IDLE.
- State LINE:
  - Data: drive `out_valid`=1 and `out_data`=word, `pix_cnt`+1. A word of `0x000` or `0x3FF` is still output but also pulses `out_error`. If `pix_cnt`==`MAX_WIDTH` before the increment: error, go to IDLE, and do not output the word.
  - LE -> FRAME: pulse `out_line_end`, `line_cnt`+1, `last_width`<=`pix_cnt`. If `line_cnt`≠0 and `pix_cnt`≠`last_width` (width mismatch): error, but continue.
  - Any other code: error, go to IDLE.
- `in_okay` low:
  - Clear both valid bits and go to IDLE.
  - Pulse `out_error` once, only if the state was not IDLE.
  - Words on beats with `in_okay` low are ignored.
- Statistics and `last_width` are not cleared by an abort; only `rst_n` clears them.

## Timing
- All outputs are registered. Strobes are one `clk` cycle wide.
- Reset: every output is 0, state is IDLE, both valid bits are clear, and all counters are 0.
- Pixel latency:
  - The word sampled on beat k is output on the cycle after beat k+2 (e.g. with `clk_en` every other cycle, k+4 cycles).
  - Gaps between beats never produce `out_valid`.
- Marker strobes, `out_stats_valid` and `out_error` assert on the cycle after the beat that carries the code.
- Priority: `rst_n` > `in_okay` low > beat processing.
- When a code causes an error and a state change on the same beat, there is one error pulse and the state change takes effect.
- `out_width` and `out_height` are stable except on the `out_stats_valid` cycle.
- Counters never wrap; overflow is reported as an error per Operation.

## Test plan
- 3 lines of 4 pixels: FS, then 3× (LS, `0x101..0x104`, LE), then FE. Require 12 `out_valid` in order, 3 `out_line_start`/`out_line_end` pulses, `out_width`=4, `out_height`=3, `out_stats_valid` once, no `out_error`.
- Latency: pixel `0x155` on beat k -> `out_valid` on the cycle after beat k+2; idle cycles between beats produce no strobes.
- Widths 4, 4, 5: one `out_error` on the third LE, `out_width`=5 at FE.
- `in_okay` dropped mid-line: one `out_error`, no further pixels; pixels sent without an FS are dropped; the next FS recovers the frame.
- Invalid code `0x3FF`,`0x000`,`0x011` in LINE: `out_error`, state IDLE, no strobes until FS.
- 753 pixels in a line: 752 `out_valid`, then `out_error`, state IDLE.

Source files
------------

// File: rtl/dlsc_mt9v032_decoder.sv
// MT9V032 word-stream decoder: strips embedded sync markers, tracks frame/line state,
// emits pixels with framing strobes, measures geometry and flags protocol errors.
module dlsc_mt9v032_decoder #(
  parameter int XBITS      = 10,
  parameter int YBITS      = 10,
  parameter int MAX_WIDTH  = 752,
  parameter int MAX_HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             in_okay,
  input  logic [9:0]       in_data,
  output logic             out_valid,
  output logic [9:0]       out_data,
  output logic             out_frame_start,
  output logic             out_line_start,
  output logic             out_line_end,
  output logic             out_frame_end,
  output logic [XBITS-1:0] out_width,
  output logic [YBITS-1:0] out_height,
  output logic             out_stats_valid,
  output logic             out_error
);

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_LINE} state_t;

  localparam logic [9:0] CODE_FS = 10'h200;
  localparam logic [9:0] CODE_LS = 10'h100;
  localparam logic [9:0] CODE_LE = 10'h080;
  localparam logic [9:0] CODE_FE = 10'h040;
  localparam logic [XBITS-1:0] MAXW = XBITS'(MAX_WIDTH);
  localparam logic [YBITS-1:0] MAXH = YBITS'(MAX_HEIGHT);

  state_t           state_reg, state_next;
  logic [9:0]       w1_reg, w1_next, w2_reg, w2_next;
  logic             v1_reg, v1_next, v2_reg, v2_next;
  logic [XBITS-1:0] pix_cnt_reg, pix_cnt_next;
  logic [XBITS-1:0] last_width_reg, last_width_next;
  logic [YBITS-1:0] line_cnt_reg, line_cnt_next;

  logic             valid_next, fs_next, ls_next, le_next, fe_next, stats_next, error_next;
  logic [9:0]       data_next;
  logic [XBITS-1:0] width_next;
  logic [YBITS-1:0] height_next;
  logic             is_marker;

  // 0x3FF,0x000 in the window means the incoming word is a sync code
  assign is_marker = v2_reg && v1_reg && (w2_reg == 10'h3FF) && (w1_reg == 10'h000);

  always_comb begin
    state_next      = state_reg;
    w1_next         = w1_reg;
    w2_next         = w2_reg;
    v1_next         = v1_reg;
    v2_next         = v2_reg;
    pix_cnt_next    = pix_cnt_reg;
    last_width_next = last_width_reg;
    line_cnt_next   = line_cnt_reg;
    valid_next      = 1'b0;
    data_next       = out_data;
    fs_next         = 1'b0;
    ls_next         = 1'b0;
    le_next         = 1'b0;
    fe_next         = 1'b0;
    stats_next      = 1'b0;
    error_next      = 1'b0;
    width_next      = out_width;
    height_next     = out_height;

    if (!in_okay) begin
      v1_next    = 1'b0;
      v2_next    = 1'b0;
      state_next = ST_IDLE;
      error_next = (state_reg != ST_IDLE);
    end else if (clk_en) begin
      if (is_marker) begin
        v1_next = 1'b0;
        v2_next = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (in_data == CODE_FS) begin
              state_next    = ST_FRAME;
              fs_next       = 1'b1;
              line_cnt_next = '0;
            end
          end
          ST_FRAME: begin
            case (in_data)
              CODE_LS: begin
                if (line_cnt_reg == MAXH) begin
                  error_next = 1'b1;
                  state_next = ST_IDLE;
                end else begin
                  state_next   = ST_LINE;
                  pix_cnt_next = '0;
                  ls_next      = 1'b1;
                end
              end
              CODE_FE: begin
                state_next  = ST_IDLE;
                fe_next     = 1'b1;
                stats_next  = 1'b1;
                height_next = line_cnt_reg;
                width_next  = last_width_reg;
              end
              CODE_FS: begin
                error_next    = 1'b1;
                fs_next       = 1'b1;
                line_cnt_next = '0;
              end
              CODE_LE: error_next = 1'b1;
              default: begin
                error_next = 1'b1;
                state_next = ST_IDLE;
              end
            endcase
          end
          ST_LINE: begin
            if (in_data == CODE_LE) begin
              state_next      = ST_FRAME;
              le_next         = 1'b1;
              line_cnt_next   = line_cnt_reg + YBITS'(1);
              last_width_next = pix_cnt_reg;
              error_next      = (line_cnt_reg != '0) && (pix_cnt_reg != last_width_reg);
            end else begin
              error_next = 1'b1;
              state_next = ST_IDLE;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end else begin
        w2_next = w1_reg;
        v2_next = v1_reg;
        w1_next = in_data;
        v1_next = 1'b1;
        // only the oldest word is known not to be part of a marker
        if (v2_reg && state_reg == ST_LINE) begin
          if (pix_cnt_reg == MAXW) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end else begin
            valid_next   = 1'b1;
            data_next    = w2_reg;
            pix_cnt_next = pix_cnt_reg + XBITS'(1);
            error_next   = (w2_reg == 10'h000) || (w2_reg == 10'h3FF);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      w1_reg          <= '0;
      w2_reg          <= '0;
      v1_reg          <= 1'b0;
      v2_reg          <= 1'b0;
      pix_cnt_reg     <= '0;
      last_width_reg  <= '0;
      line_cnt_reg    <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_frame_start <= 1'b0;
      out_line_start  <= 1'b0;
      out_line_end    <= 1'b0;
      out_frame_end   <= 1'b0;
      out_width       <= '0;
      out_height      <= '0;
      out_stats_valid <= 1'b0;
      out_error       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      w1_reg          <= w1_next;
      w2_reg          <= w2_next;
      v1_reg          <= v1_next;
      v2_reg          <= v2_next;
      pix_cnt_reg     <= pix_cnt_next;
      last_width_reg  <= last_width_next;
      line_cnt_reg    <= line_cnt_next;
      out_valid       <= valid_next;
      out_data        <= data_next;
      out_frame_start <= fs_next;
      out_line_start  <= ls_next;
      out_line_end    <= le_next;
      out_frame_end   <= fe_next;
      out_width       <= width_next;
      out_height      <= height_next;
      out_stats_valid <= stats_next;
      out_error       <= error_next;
    end
  end

endmodule

// File: tb/tb_dlsc_mt9v032_decoder.sv
// Scoreboard bench for dlsc_mt9v032_decoder: directed word streams push expected
// output events; a negedge monitor pops and compares every event the DUT emits.
module tb_dlsc_mt9v032_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b0;
  logic       in_okay = 1'b1;
  logic [9:0] in_data = '0;
  logic       out_valid, out_frame_start, out_line_start, out_line_end, out_frame_end;
  logic       out_stats_valid, out_error;
  logic [9:0] out_data, out_width, out_height;

  dlsc_mt9v032_decoder dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .in_okay(in_okay), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .out_frame_start(out_frame_start), .out_line_start(out_line_start),
    .out_line_end(out_line_end), .out_frame_end(out_frame_end),
    .out_width(out_width), .out_height(out_height),
    .out_stats_valid(out_stats_valid), .out_error(out_error)
  );

  always #5 clk = ~clk;

  // event flags: {err, stats, fe, le, ls, fs, valid}
  localparam logic [6:0] F_VAL = 7'h01, F_FS = 7'h02, F_LS = 7'h04, F_LE = 7'h08;
  localparam logic [6:0] F_FE = 7'h10, F_ST = 7'h20, F_ERR = 7'h40;

  logic [36:0] sb_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int gap = 0;
  int beat_cyc = 0;
  int k2_cyc = -1;
  int valid_cyc = -1;

  always @(posedge clk) cyc++;

  function automatic logic [36:0] ev(input logic [6:0] f, input logic [9:0] d,
                                     input logic [9:0] w, input logic [9:0] h);
    return {f, d, w, h};
  endfunction

  task automatic exp_f(input logic [6:0] f);
    sb_q.push_back(ev(f, 10'h0, 10'h0, 10'h0));
  endtask

  task automatic exp_px(input logic [9:0] d);
    sb_q.push_back(ev(F_VAL, d, 10'h0, 10'h0));
  endtask

  task automatic exp_fe(input logic [9:0] w, input logic [9:0] h);
    sb_q.push_back(ev(F_FE | F_ST, 10'h0, w, h));
  endtask

  task automatic exp_line(input logic [9:0] base, input int n, input logic err);
    exp_f(F_LS);
    for (int i = 0; i < n; i++) exp_px(base + 10'(i));
    exp_f(err ? (F_LE | F_ERR) : F_LE);
  endtask

  // Monitor: every cycle with any strobe is one event, compared against the queue head
  always @(negedge clk) begin
    logic [36:0] obs, want;
    if (rst_n && (out_valid || out_frame_start || out_line_start || out_line_end ||
                  out_frame_end || out_stats_valid || out_error)) begin
      obs = ev({out_error, out_stats_valid, out_frame_end, out_line_end, out_line_start,
                out_frame_start, out_valid},
               out_valid ? out_data : 10'h0,
               out_stats_valid ? out_width : 10'h0,
               out_stats_valid ? out_height : 10'h0);
      if (out_valid && out_data == 10'h155) valid_cyc = cyc;
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL event: got flags=%b data=%h w=%0d h=%0d, required no event",
                 obs[36:30], obs[29:20], obs[19:10], obs[9:0]);
      end else begin
        want = sb_q.pop_front();
        if (obs === want) begin
          passes++;
          $display("ok   event flags=%b data=%h w=%0d h=%0d", obs[36:30], obs[29:20],
                   obs[19:10], obs[9:0]);
        end else
          $display("FAIL event: got flags=%b data=%h w=%0d h=%0d, required flags=%b data=%h w=%0d h=%0d",
                   obs[36:30], obs[29:20], obs[19:10], obs[9:0],
                   want[36:30], want[29:20], want[19:10], want[9:0]);
      end
    end
  end

  task automatic beat(input logic [9:0] w);
    @(negedge clk);
    clk_en   = 1'b1;
    in_data  = w;
    beat_cyc = cyc + 1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic marker(input logic [9:0] code);
    beat(10'h3FF);
    beat(10'h000);
    beat(code);
  endtask

  task automatic send_line(input logic [9:0] base, input int n);
    marker(10'h100);
    for (int i = 0; i < n; i++) beat(base + 10'(i));
    marker(10'h080);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_frame_start, out_line_start, out_line_end, out_frame_end,
         out_width, out_height, out_stats_valid, out_error} === '0) passes++;
    else $display("FAIL reset: outputs not all zero (valid=%b data=%h w=%0d h=%0d err=%b), required 0",
                  out_valid, out_data, out_width, out_height, out_error);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3 lines of 4 pixels
    exp_f(F_FS);
    for (int l = 0; l < 3; l++) exp_line(10'h101, 4, 1'b0);
    exp_fe(10'd4, 10'd3);
    marker(10'h200);
    for (int l = 0; l < 3; l++) send_line(10'h101, 4);
    marker(10'h040);

    // Latency with idle cycles between beats
    gap = 3;
    exp_f(F_FS); exp_f(F_LS);
    exp_px(10'h155); exp_px(10'h156); exp_px(10'h157);
    exp_f(F_LE); exp_fe(10'd3, 10'd1);
    marker(10'h200);
    marker(10'h100);
    beat(10'h155);
    beat(10'h156);
    beat(10'h157);
    k2_cyc = beat_cyc;
    marker(10'h080);
    marker(10'h040);
    gap = 0;
    checks++;
    if (valid_cyc == k2_cyc) passes++;
    else $display("FAIL latency: pixel 0x155 out_valid at cycle %0d, required %0d", valid_cyc, k2_cyc);

    // Widths 4,4,5: mismatch on the third line end
    exp_f(F_FS);
    exp_line(10'h010, 4, 1'b0);
    exp_line(10'h010, 4, 1'b0);
    exp_line(10'h010, 5, 1'b1);
    exp_fe(10'd5, 10'd3);
    marker(10'h200);
    send_line(10'h010, 4);
    send_line(10'h010, 4);
    send_line(10'h010, 5);
    marker(10'h040);

    // in_okay dropped mid-line, orphan line ignored, FS recovers
    exp_f(F_FS); exp_f(F_LS); exp_px(10'h021); exp_f(F_ERR);
    marker(10'h200);
    marker(10'h100);
    beat(10'h021); beat(10'h022); beat(10'h023);
    @(negedge clk);
    in_okay = 1'b0; clk_en = 1'b1; in_data = 10'h024;
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    in_okay = 1'b1;
    send_line(10'h030, 4);
    exp_f(F_FS); exp_line(10'h041, 2, 1'b0); exp_fe(10'd2, 10'd1);
    marker(10'h200);
    send_line(10'h041, 2);
    marker(10'h040);

    // Invalid code in LINE, then no strobes until FS
    exp_f(F_FS); exp_f(F_LS); exp_px(10'h051); exp_px(10'h052); exp_f(F_ERR);
    marker(10'h200);
    marker(10'h100);
    beat(10'h051); beat(10'h052);
    marker(10'h011);
    beat(10'h070); beat(10'h071); beat(10'h072);
    marker(10'h080);
    marker(10'h040);
    exp_f(F_FS); exp_line(10'h061, 1, 1'b0); exp_fe(10'd1, 10'd1);
    marker(10'h200);
    send_line(10'h061, 1);
    marker(10'h040);

    // 753 pixels: 752 outputs then an overflow error; the trailing LE is ignored in IDLE
    exp_f(F_FS); exp_f(F_LS);
    for (int i = 0; i < 752; i++) exp_px(10'h100 + 10'(i % 256));
    exp_f(F_ERR);
    marker(10'h200);
    marker(10'h100);
    for (int i = 0; i < 753; i++) beat(10'h100 + 10'(i % 256));
    marker(10'h080);
    marker(10'h040);

    repeat (10) @(negedge clk);
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL drain: %0d expected events never seen, required 0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
